// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator. Operands are compared one CHUNK-bit slice
// per cycle from the most significant slice down. The compare stops at the
// first slice that differs. Result flags stay registered until the next
// accepted start.
module seq_comparator #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic             done,
   output logic             larger,
   output logic             equal,
   output logic             smaller
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] sign_mask;
   logic [CHUNK-1:0] slice_a, slice_b;
   logic             accept, slice_gt, slice_lt, last_slice;

   // A new request is taken whenever the comparator is not mid-compare.
   assign accept     = start && (state != RUN);
   assign slice_gt   = slice_a > slice_b;
   assign slice_lt   = slice_a < slice_b;
   assign last_slice = (idx == '0);
   assign busy       = (state == RUN);
   assign done       = (state == DONE);

   // Flipping the sign bit of both operands turns a two's-complement compare
   // into an unsigned one, so the slice logic never needs to know the mode.
   always_comb begin
      sign_mask          = '0;
      sign_mask[WIDTH-1] = is_signed;
   end

   // Select the slice currently being examined from each captured operand.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDXW'(i)) begin
            slice_a = a_q[i*CHUNK +: CHUNK];
            slice_b = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: run until a slice differs or the last slice is done.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (slice_gt || slice_lt || last_slice) state_nx = DONE;
         DONE: state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, slice index and result flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the captured operands are cleared too, so the datapath never holds X after reset.
         a_q     <= '0;
         b_q     <= '0;
         idx     <= '0;
         larger  <= 1'b0;
         equal   <= 1'b0;
         smaller <= 1'b0;
      end else if (accept) begin
         a_q     <= SrcA ^ sign_mask;
         b_q     <= SrcB ^ sign_mask;
         idx     <= IDXW'(NCHUNK - 1);
         larger  <= 1'b0;
         equal   <= 1'b0;
         smaller <= 1'b0;
      end else if (state == RUN) begin
         if (slice_gt)        larger  <= 1'b1;
         else if (slice_lt)   smaller <= 1'b1;
         else if (last_slice) equal   <= 1'b1;
         else                 idx     <= idx - IDXW'(1);
      end
   end

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator: directed table, hand-written
// handshake/reset sequences and randomized compares against a reference model.
module tb_seq_comparator;

   localparam int W = 32;
   localparam int C = 8;
   localparam int N = W / C;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         is_signed;
   logic [W-1:0] SrcA, SrcB;

   logic busy8, done8, larger8, equal8, smaller8;
   logic busy32, done32, larger32, equal32, smaller32;

   bit       use32 = 1'b0;
   logic       cur_busy, cur_done;
   logic [2:0] cur_flags;

   int n_vec = 0;
   int n_bad = 0;

   seq_comparator #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .SrcA(SrcA), .SrcB(SrcB), .busy(busy8), .done(done8),
      .larger(larger8), .equal(equal8), .smaller(smaller8)
   );

   seq_comparator #(.WIDTH(W), .CHUNK(W)) dut32 (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .SrcA(SrcA), .SrcB(SrcB), .busy(busy32), .done(done32),
      .larger(larger32), .equal(equal32), .smaller(smaller32)
   );

   always #5 clk = ~clk;

   assign cur_busy  = use32 ? busy32 : busy8;
   assign cur_done  = use32 ? done32 : done8;
   assign cur_flags = use32 ? {larger32, equal32, smaller32} : {larger8, equal8, smaller8};

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [2:0]   flags;   // {larger, equal, smaller}
      int           k;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: flags from plain signed/unsigned arithmetic, latency from the
   // position of the highest differing bit.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [2:0] f, output int k);
      logic [W-1:0] diff;
      int top;
      if (a == b)                                  f = 3'b010;
      else if (s ? ($signed(a) > $signed(b)) : (a > b)) f = 3'b100;
      else                                         f = 3'b001;
      diff = a ^ b;
      top  = -1;
      for (int p = 0; p < W; p++) if (diff[p]) top = p;
      k = (top < 0) ? N : N - top / C;
   endtask

   // Present a request; returns just after the accepting edge with start low.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      SrcA = a; SrcB = b; is_signed = s; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called just after the accepting edge: waits (bounded) for done and checks
   // the latency in edges plus the result flags.
   task automatic wait_result(input logic [2:0] exp_f, input int exp_k, input string name);
      int j = 0;
      while (!cur_done && j < N + 3) begin
         check({name, " busy while running"}, {31'd0, cur_busy}, 32'd1);
         check({name, " flags while running"}, {29'd0, cur_flags}, 32'd0);
         tick();
         j++;
      end
      check({name, " latency"}, j, exp_k);
      check({name, " done"}, {31'd0, cur_done}, 32'd1);
      check({name, " busy at done"}, {31'd0, cur_busy}, 32'd0);
      check({name, " flags"}, {29'd0, cur_flags}, {29'd0, exp_f});
   endtask

   vec_t tbl[8];

   initial begin
      logic [2:0]   ef;
      int           ek;
      logic [W-1:0] ra, rb;
      logic         rs;

      tbl[0] = '{32'h12345678, 32'h12345679, 1'b0, 3'b001, 4};
      tbl[1] = '{32'h80000000, 32'h00000001, 1'b1, 3'b001, 1};
      tbl[2] = '{32'h80000000, 32'h00000001, 1'b0, 3'b100, 1};
      tbl[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b010, 4};
      tbl[4] = '{32'h00000005, 32'h00000003, 1'b0, 3'b100, 4};
      tbl[5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 3'b001, 1};
      tbl[6] = '{32'h00FF0000, 32'h00FE0000, 1'b0, 3'b100, 2};
      tbl[7] = '{32'h00001200, 32'h00001300, 1'b1, 3'b001, 3};

      // Reset held with a pending request: nothing may start.
      reset = 1'b0; start = 1'b1; SrcA = 32'd1; SrcB = 32'd2; is_signed = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset busy", {31'd0, busy8}, 32'd0);
         check("reset done", {31'd0, done8}, 32'd0);
         check("reset flags", {29'd0, larger8, equal8, smaller8}, 32'd0);
      end
      reset = 1'b1;
      tick();            // first edge after release accepts 1 vs 2
      start = 1'b0;
      wait_result(3'b001, 4, "post-reset");
      tick();
      check("post-reset idle", {31'd0, done8}, 32'd0);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].s);
         wait_result(tbl[i].flags, tbl[i].k, $sformatf("table[%0d]", i));
         tick();
         check($sformatf("table[%0d] done one cycle", i), {31'd0, done8}, 32'd0);
         check($sformatf("table[%0d] flags held", i), {29'd0, larger8, equal8, smaller8},
               {29'd0, tbl[i].flags});
      end

      // Equal result holds for several idle cycles.
      launch(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
      wait_result(3'b010, 4, "equal hold");
      repeat (5) tick();
      check("equal held 5 cycles", {29'd0, larger8, equal8, smaller8}, 32'd2);
      check("equal idle busy", {31'd0, busy8}, 32'd0);

      // Start during RUN is ignored; start during DONE is accepted back-to-back.
      launch(32'h12345678, 32'h12345679, 1'b0);
      SrcA = 32'hFFFFFFFF; SrcB = 32'h0; is_signed = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_result(3'b001, 3, "start in run ignored");
      launch(32'd5, 32'd3, 1'b0);
      check("b2b flags cleared", {29'd0, larger8, equal8, smaller8}, 32'd0);
      wait_result(3'b100, 4, "b2b");
      tick();

      // Same handshake with a single full-width slice.
      use32 = 1'b1;
      launch(32'h12345678, 32'h12345679, 1'b0);
      SrcA = 32'hFFFFFFFF; SrcB = 32'h0; start = 1'b1;
      wait_result(3'b001, 1, "c32 first");
      start = 1'b0;
      launch(32'd5, 32'd3, 1'b0);
      wait_result(3'b100, 1, "c32 b2b");
      launch(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
      wait_result(3'b010, 1, "c32 equal");
      tick();
      use32 = 1'b0;
      repeat (2) tick();

      // Asynchronous reset in the middle of a compare.
      launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      tick();
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("abort busy", {31'd0, busy8}, 32'd0);
      check("abort flags", {29'd0, larger8, equal8, smaller8}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort no done", {31'd0, done8}, 32'd0);
      end
      reset = 1'b1;
      tick();

      // Randomized compares, often sharing upper slices to vary latency.
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         rs = 1'($urandom_range(1));
         case ($urandom_range(3))
            0:       rb = $urandom;
            1:       rb = ra;
            default: rb = ra ^ ($urandom >> $urandom_range(31));
         endcase
         model(ra, rb, rs, ef, ek);
         launch(ra, rb, rs);
         wait_result(ef, ek, $sformatf("rand %0d a=%0h b=%0h s=%0d", i, ra, rb, rs));
         if ($urandom_range(1) == 1) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
